food_map_ctrl: RTL and testbench
================================

Name: food_map_ctrl

Overview:
- Owns the live food map for the maze: 50 rows x 80 columns, one bit per 16x16 tile; a set bit means food is present on that tile.
- On reset or level restart, copies the wall/corridor map from the map block ROM into food storage.
- Serves row reads to the renderer via food_idx_y/food_row.
- Clears food bits when game logic reports Pac-Man entering a tile, and maintains a 4-digit BCD score and a remaining-food count.

Parameters:
- MAP_ROWS, 50, number of tile rows.
- MAP_COLS, 80, number of tile columns; this is the row word width.
- FOOD_PTS, 1, BCD value added to the tens digit per food eaten (1 = 10 points).
- POWER_PTS, 5, BCD value added to the tens digit per power pellet (used only with the option).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- restart  in  1  level restart: reload food from the map, keep the score.
- map_addr  out  6  row address to the map ROM (1-cycle read latency).
- map_row  in  80  ROM row data; bit c=1 means corridor.
- food_idx_y  in  6  renderer read row.
- food_row  out  80  registered food row for food_idx_y.
- eat_req  in  1  tile-entry strobe from game logic.
- eat_tile_x  in  7  tile column of the strobe.
- eat_tile_y  in  6  tile row of the strobe.
- busy  out  1  high when eat_req is not accepted.
- eat_ack  out  1  1-cycle pulse: eat request processed.
- eaten  out  1  qualifies eat_ack; food was present and has been cleared.
- score  out  16  BCD score, 4 digits, [15:12] is the most significant digit.
- food_left  out  12  remaining food bits.
- level_done  out  1  high while food_left==0 after a completed load.
- power_pulse  out  1  1-cycle pulse when a power pellet is eaten (option only).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state INIT, row counter 0, map_addr 0.
  - score 0, food_left 0, food_row 0.
  - busy 1; eat_ack, eaten, level_done, power_pulse all 0.
  - Food array contents are don't-care until INIT overwrites them.
- States: INIT, IDLE, CHECK.
- INIT:
  - Issues map_addr r on cycle r (r = 0..49).
  - On cycle r+1, writes map_row into food row r and adds popcount(map_row) to food_left.
  - food_left is cleared on entry to INIT.
  - After writing row 49 (cycle 50), goes to IDLE; busy falls on the following cycle, 51 cycles after entry.
  - level_done is held 0 during INIT.
- IDLE:
  - busy=0.
  - eat_req=1 latches the tile coordinates and moves to CHECK.
  - If the coordinates are out of range (x>=80 or y>=50), the request is still acked, with eaten=0 and no state change.
- CHECK (one cycle):
  - busy=1 and eat_ack=1.
  - If the addressed bit is 1:
    - clear the bit;
    - eaten=1;
    - food_left decrements;
    - score adds FOOD_PTS to the tens digit with full BCD carry;
    - score saturates at 16'h9999 and never wraps.
  - If the addressed bit is 0, eaten=0 and nothing else changes.
  - Returns to IDLE.
- eat_req while busy=1 is dropped with no ack; game logic must hold or re-issue the request.
- level_done:
  - Registered; rises the cycle after food_left becomes 0 outside INIT.
  - Stays high until restart or reset.
  - An empty map (popcount 0) gives level_done=1 immediately after INIT.
- restart=1 in any state:
  - Aborts the current operation and enters INIT at row 0.
  - score is preserved; a CHECK in progress on the same cycle is discarded.
  - rst_n has priority over restart.
- Read port:
  - food_row is registered: food_row <= food[food_idx_y], 1-cycle latency, every cycle, in all states.
  - food_idx_y>=50 returns 0.
  - Reading a row that CHECK clears in the same cycle returns the old value (read-before-write); the new value is returned from the next cycle on.
- Bit c of food_row corresponds to tile column c, the same indexing as map_row.

Optional Feature:
- Macro FOOD_MAP_CTRL_POWER_PELLET_EN.
- When defined:
  - Tiles (1,1), (78,1), (1,48) and (78,48) are power pellets.
  - Eating one adds POWER_PTS instead of FOOD_PTS to the tens digit.
  - power_pulse is asserted in the same cycle as eat_ack.
- When undefined: all tiles score FOOD_PTS and power_pulse is tied to 0.

Test Plan:
- Reset with a ROM of 50 rows of 80'h1 (popcount 1 per row):
  - busy=1 for exactly 51 cycles after reset release, then 0;
  - food_left=50, score=0, level_done=0;
  - food_idx_y=7 gives food_row=80'h1 one cycle later.
- eat_req at (0,3) with the bit set:
  - one cycle later eat_ack=1, eaten=1;
  - food_left 50->49, score 16'h0010;
  - food_row for row 3 becomes 0.
- Repeat eat_req at (0,3): eat_ack=1, eaten=0, score stays 16'h0010. A request at (85,3) gives eat_ack=1, eaten=0, with no change.
- Preload score 16'h9990 via repeated eats with a dense ROM row:
  - the next eat gives 16'h9999;
  - a further eat keeps 16'h9999.
- Eat all 50 food tiles: level_done goes high one cycle after the 50th ack. Then restart=1:
  - level_done=0 and busy=1 for 51 cycles;
  - food_left=50 again, score unchanged.
- With FOOD_MAP_CTRL_POWER_PELLET_EN and an all-ones ROM, eat at (1,1): score +16'h0050 and power_pulse=1 in the eat_ack cycle. Without the macro, the same eat gives +16'h0010 and power_pulse=0.

Source files
------------

// File: rtl/food_map_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | food_map_ctrl : live food bitmap, BCD score and food count for the maze.   |
// | Option macro FOOD_MAP_CTRL_POWER_PELLET_EN enables corner power pellets.   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module food_map_ctrl #(
    parameter int MAP_ROWS  = 50,
    parameter int MAP_COLS  = 80,
    parameter int FOOD_PTS  = 1,
    parameter int POWER_PTS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    output logic [5:0]          map_addr,
    input  logic [MAP_COLS-1:0] map_row,
    input  logic [5:0]          food_idx_y,
    output logic [MAP_COLS-1:0] food_row,
    input  logic                eat_req,
    input  logic [6:0]          eat_tile_x,
    input  logic [5:0]          eat_tile_y,
    output logic                busy,
    output logic                eat_ack,
    output logic                eaten,
    output logic [15:0]         score,
    output logic [11:0]         food_left,
    output logic                level_done,
    output logic                power_pulse
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [3:0] FOOD_BCD  = 4'(FOOD_PTS);
    localparam logic [3:0] POWER_BCD = 4'(POWER_PTS);

    state_t              state_q, state_d;
    logic [5:0]          row_q, row_d;
    logic [6:0]          x_q, x_d;
    logic [5:0]          y_q, y_d;
    logic [15:0]         score_q, score_d;
    logic [11:0]         left_q, left_d;
    logic                done_q, done_d;
    logic [MAP_COLS-1:0] food_row_q, food_row_d;

    logic [MAP_COLS-1:0] food_q [MAP_ROWS];

    logic                in_range;
    logic [MAP_COLS-1:0] cur_row;
    logic                hit;
    logic                is_pellet;
    logic [3:0]          pts;
    logic                wr_en;
    logic [5:0]          wr_idx;
    logic [MAP_COLS-1:0] wr_data;

    function automatic logic [11:0] popcount(input logic [MAP_COLS-1:0] v);
        logic [11:0] n;
        n = '0;
        for (int i = 0; i < MAP_COLS; i++) begin
            n = n + 12'(v[i]);
        end
        return n;
    endfunction

    // Adds pts to the tens digit, rippling carries upward; overflow pins at 9999.
    function automatic logic [15:0] bcd_add_tens(input logic [15:0] s, input logic [3:0] p);
        logic [4:0]  t;
        logic        c;
        logic [15:0] r;
        r = s;
        t = {1'b0, s[7:4]} + {1'b0, p};
        c = (t > 5'd9);
        if (c) t = t - 5'd10;
        r[7:4] = t[3:0];
        t = {1'b0, s[11:8]} + {4'd0, c};
        c = (t > 5'd9);
        if (c) t = t - 5'd10;
        r[11:8] = t[3:0];
        t = {1'b0, s[15:12]} + {4'd0, c};
        c = (t > 5'd9);
        if (c) t = t - 5'd10;
        r[15:12] = t[3:0];
        if (c) r = 16'h9999;
        return r;
    endfunction

`ifdef FOOD_MAP_CTRL_POWER_PELLET_EN
    assign is_pellet = ((x_q == 7'd1) || (x_q == 7'(MAP_COLS - 2))) &&
                       ((y_q == 6'd1) || (y_q == 6'(MAP_ROWS - 2)));
`else
    assign is_pellet = 1'b0;
`endif

    assign pts      = is_pellet ? POWER_BCD : FOOD_BCD;
    assign in_range = (x_q < 7'(MAP_COLS)) && (y_q < 6'(MAP_ROWS));
    assign cur_row  = food_q[in_range ? y_q : 6'd0];
    assign hit      = (state_q == ST_CHECK) && !restart && in_range && cur_row[x_q];

    // Row 0 of INIT only issues the first ROM address; data arrives one cycle later.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (!restart) begin
            if (state_q == ST_INIT && row_q != 6'd0) begin
                wr_en   = 1'b1;
                wr_idx  = row_q - 6'd1;
                wr_data = map_row;
            end else if (hit) begin
                wr_en   = 1'b1;
                wr_idx  = y_q;
                wr_data = cur_row & ~(MAP_COLS'(1) << x_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        left_d  = left_q;
        case (state_q)
            ST_INIT: begin
                row_d = row_q + 6'd1;
                if (row_q != 6'd0) begin
                    left_d = left_q + popcount(map_row);
                end
                if (row_q == 6'(MAP_ROWS)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (eat_req) begin
                    x_d     = eat_tile_x;
                    y_d     = eat_tile_y;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (hit) begin
                    left_d  = left_q - 12'd1;
                    score_d = bcd_add_tens(score_q, pts);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
        if (restart) begin
            state_d = ST_INIT;
            row_d   = '0;
            left_d  = '0;
            score_d = score_q;
        end
        done_d = (state_d == ST_INIT) ? 1'b0 : (done_q || (left_d == 12'd0));
        food_row_d = (food_idx_y < 6'(MAP_ROWS)) ? food_q[food_idx_y] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            row_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            score_q    <= '0;
            left_q     <= '0;
            done_q     <= 1'b0;
            food_row_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            x_q        <= x_d;
            y_q        <= y_d;
            score_q    <= score_d;
            left_q     <= left_d;
            done_q     <= done_d;
            food_row_q <= food_row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            food_q[wr_idx] <= wr_data;
        end
    end

    assign map_addr    = row_q;
    assign food_row    = food_row_q;
    assign busy        = (state_q != ST_IDLE);
    assign eat_ack     = (state_q == ST_CHECK) && !restart;
    assign eaten       = hit;
    assign power_pulse = hit && is_pellet;
    assign score       = score_q;
    assign food_left   = left_q;
    assign level_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_food_map_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_food_map_ctrl : randomized bench for food_map_ctrl against a tile model. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_food_map_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic [5:0]  map_addr;
    logic [79:0] map_row;
    logic [5:0]  food_idx_y;
    logic [79:0] food_row;
    logic        eat_req;
    logic [6:0]  eat_tile_x;
    logic [5:0]  eat_tile_y;
    logic        busy, eat_ack, eaten, level_done, power_pulse;
    logic [15:0] score;
    logic [11:0] food_left;

    always #5 clk = ~clk;

    food_map_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .map_addr   (map_addr),
        .map_row    (map_row),
        .food_idx_y (food_idx_y),
        .food_row   (food_row),
        .eat_req    (eat_req),
        .eat_tile_x (eat_tile_x),
        .eat_tile_y (eat_tile_y),
        .busy       (busy),
        .eat_ack    (eat_ack),
        .eaten      (eaten),
        .score      (score),
        .food_left  (food_left),
        .level_done (level_done),
        .power_pulse(power_pulse)
    );

    logic [79:0] rom [50];
    always @(posedge clk) map_row <= (map_addr < 6'd50) ? rom[map_addr] : 80'd0;

    logic [79:0] mfood [50];
    int          mleft;
    int          mscore;
    bit          mdone;
    int          checks = 0;
    int          errors = 0;
    int          sx = 0;
    int          sy = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit pellet(input int x, input int y);
`ifdef FOOD_MAP_CTRL_POWER_PELLET_EN
        return ((x == 1) || (x == 78)) && ((y == 1) || (y == 48));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_load();
        mleft = 0;
        for (int r = 0; r < 50; r++) begin
            mfood[r] = rom[r];
            mleft += $countones(rom[r]);
        end
        mdone = (mleft == 0);
    endtask

    // Called at the negedge of the first INIT cycle.
    task automatic wait_load(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 80'(n), 80'd51);
        check({tag, "_food_left"}, 80'(food_left), 80'(mleft));
        check({tag, "_score"}, 80'(score), 80'(to_bcd(mscore)));
        check({tag, "_level_done"}, 80'(level_done), 80'(mdone));
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        @(negedge clk);
        check("restart_level_done", 80'(level_done), 80'd0);
        model_load();
        wait_load("restart");
    endtask

    task automatic do_eat(input int x, input int y);
        int  n = 0;
        bit  exp_hit;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("eat_ready", 80'(busy), 80'd0);
        eat_req    = 1'b1;
        eat_tile_x = 7'(x);
        eat_tile_y = 6'(y);
        @(posedge clk);
        #1 eat_req = 1'b0;
        @(negedge clk);
        exp_hit = (x < 80) && (y < 50) && mfood[(y < 50) ? y : 0][(x < 80) ? x : 0];
        check("ack", 80'(eat_ack), 80'd1);
        check("ack_busy", 80'(busy), 80'd1);
        check("eaten", 80'(eaten), 80'(exp_hit));
        check("power_pulse", 80'(power_pulse), 80'(exp_hit && pellet(x, y)));
        check("done_at_ack", 80'(level_done), 80'(mdone));
        if (exp_hit) begin
            mfood[y][x] = 1'b0;
            mleft--;
            mscore += pellet(x, y) ? 50 : 10;
            if (mscore > 9999) mscore = 9999;
            if (mleft == 0) mdone = 1'b1;
        end
        @(negedge clk);
        check("food_left", 80'(food_left), 80'(mleft));
        check("score", 80'(score), 80'(to_bcd(mscore)));
        @(negedge clk);
        check("level_done", 80'(level_done), 80'(mdone));
    endtask

    task automatic check_row(input int y);
        @(negedge clk);
        food_idx_y = 6'(y);
        @(negedge clk);
        check("food_row", food_row, (y < 50) ? mfood[y] : 80'd0);
    endtask

    // Walks the map in raster order, eating the next ordinary food tile.
    task automatic eat_next();
        bit found = 1'b0;
        while (!found && sy < 50) begin
            if (!pellet(sx, sy) && mfood[sy][sx]) begin
                do_eat(sx, sy);
                found = 1'b1;
            end
            sx++;
            if (sx == 80) begin
                sx = 0;
                sy++;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        restart    = 1'b0;
        eat_req    = 1'b0;
        eat_tile_x = '0;
        eat_tile_y = '0;
        food_idx_y = '0;
        mscore     = 0;
        for (int r = 0; r < 50; r++) rom[r] = 80'h1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 80'(busy), 80'd1);
        check("rst_score", 80'(score), 80'd0);
        check("rst_food_left", 80'(food_left), 80'd0);
        check("rst_food_row", food_row, 80'd0);
        check("rst_map_addr", 80'(map_addr), 80'd0);
        check("rst_flags", 80'({eat_ack, eaten, level_done, power_pulse}), 80'd0);
        rst_n = 1'b1;
        model_load();
        wait_load("reset");

        check_row(7);
        do_eat(0, 3);
        check_row(3);
        do_eat(0, 3);
        do_eat(85, 3);
        check_row(55);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0)
                do_eat($urandom_range(0, 90), $urandom_range(0, 55));
            else
                do_eat($urandom_range(0, 3), $urandom_range(0, 49));
            check_row($urandom_range(0, 55));
        end

        for (int y = 0; y < 50; y++) do_eat(0, y);
        check("all_eaten_done", 80'(level_done), 80'd1);
        check("all_eaten_left", 80'(food_left), 80'd0);

        do_restart();
        check_row($urandom_range(0, 49));

        for (int r = 0; r < 50; r++) rom[r] = {80{1'b1}};
        do_restart();
        do_eat(1, 1);

        while (mscore != 9990 && sy < 50) eat_next();
        check("pre_sat", 80'(score), 80'h9990);
        eat_next();
        check("sat_first", 80'(score), 80'h9999);
        eat_next();
        check("sat_hold", 80'(score), 80'h9999);
        check_row(0);
        check_row($urandom_range(0, 55));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
